// File: rtl/kypd_pkg.sv
// ----------------------------------------------------------------------------
// kypd_pkg
// Shared definitions for the 4x4 hex keypad scanner:
//   - state_e      : scanner FSM states
//   - COL_RESET    : column drive value after reset (left column low)
//   - KEY_MAP      : 16-entry hex code table indexed {row_idx, col_idx}
//   - row_hit_t    : result of one-hot-low row detection
//   - row_decode() : classifies a row sample as a single press or no press
// ----------------------------------------------------------------------------
package kypd_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_e;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Entry {row, col}. Physical layout (col0..col3):
    //   row0: 1 2 3 A
    //   row1: 4 5 6 B
    //   row2: 7 8 9 C
    //   row3: 0 F E D
    // Listed from index 15 down to index 0.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } row_hit_t;

    // Exactly one low row is a press; none or several low rows (ghosting)
    // are rejected as no press.
    function automatic row_hit_t row_decode(input logic [3:0] row);
        row_hit_t hit;
        hit.valid = 1'b1;
        hit.idx   = 2'd0;
        case (row)
            4'b1110: hit.idx = 2'd0;
            4'b1101: hit.idx = 2'd1;
            4'b1011: hit.idx = 2'd2;
            4'b0111: hit.idx = 2'd3;
            default: hit.valid = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/scan_clk.sv
// ----------------------------------------------------------------------------
// scan_clk
// Divides the system clock into a single-cycle scan tick.
// The counter runs 0..SCAN_DIV-1 and o_tick is high during the cycle in
// which the count equals SCAN_DIV-1; the counter then wraps to 0.
//
// Ports:
//   i_clk   : system clock
//   i_reset : synchronous active-low reset (clears the counter)
//   o_tick  : one-clk pulse every SCAN_DIV clks
// ----------------------------------------------------------------------------
module scan_clk #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick
);

    localparam int unsigned CNT_W = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == CNT_MAX);
    assign o_tick = w_tick;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// ----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 hex keypad by driving one column low at a time and reading
// the rows on each scan tick. A press must be seen on DEBOUNCE_TICKS
// consecutive ticks to be accepted, and a release likewise. Each accepted
// key is shifted into an 8-nibble history that feeds a display directly.
//
// Ports:
//   i_clk       : system clock
//   i_reset     : synchronous active-low reset, dominates everything
//   i_row       : keypad rows, active-low, [0] = top row
//   o_col       : column drive, active-low one-cold, [0] = left column
//   o_key_code  : hex code of the last accepted key
//   o_key_valid : one-clk pulse when a new key is accepted
//   o_key_held  : high from accept until the release is debounced
//   o_digits    : key history, [3:0] newest ... [31:28] oldest
// ----------------------------------------------------------------------------
module keypad_scanner
    import kypd_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_row,
    output logic [3:0]  o_col,
    output logic [3:0]  o_key_code,
    output logic        o_key_valid,
    output logic        o_key_held,
    output logic [31:0] o_digits
);

    localparam int unsigned DB_W = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS);
    // With a single required tick the debounce/release states are skipped.
    localparam bit SINGLE_TICK = (DEBOUNCE_TICKS == 1);

    // Tick generation
    logic w_tick;

    scan_clk #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_clk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_tick  (w_tick)
    );

    // State and datapath registers
    state_e          r_state;
    state_e          w_state_next;
    logic [3:0]      r_col;
    logic [1:0]      r_col_idx;
    logic [1:0]      r_row_idx;
    logic [3:0]      r_cand;
    logic [DB_W-1:0] r_db_cnt;
    logic [3:0]      r_key_code;
    logic            r_key_valid;
    logic            r_key_held;
    logic [31:0]     r_digits;

    // Row classification and derived conditions
    row_hit_t        w_hit;
    logic            w_row_match;
    logic            w_row_high;
    logic [DB_W-1:0] w_cnt_inc;
    logic            w_cnt_done;
    logic [3:0]      w_cand_new;
    logic [3:0]      w_accept_code;

    // Control outputs of the FSM
    logic            w_latch;
    logic            w_accept;
    logic            w_release;
    logic            w_rotate;
    logic [DB_W-1:0] w_db_cnt_next;

    assign w_hit         = row_decode(i_row);
    assign w_row_match   = w_hit.valid && (w_hit.idx == r_row_idx);
    assign w_row_high    = i_row[r_row_idx];
    assign w_cnt_inc     = r_db_cnt + DB_ONE;
    assign w_cnt_done    = (w_cnt_inc == DB_LAST);
    assign w_cand_new    = KEY_MAP[{w_hit.idx, r_col_idx}];
    // An immediate accept from SCAN uses the code being latched this cycle.
    assign w_accept_code = w_latch ? w_cand_new : r_cand;

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic (only ticks move the FSM)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_tick) begin
            unique case (r_state)
                SCAN: begin
                    if (w_hit.valid) begin
                        w_state_next = SINGLE_TICK ? HELD : DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!w_row_match) begin
                        w_state_next = SCAN;
                    end else if (w_cnt_done) begin
                        w_state_next = HELD;
                    end
                end
                HELD: begin
                    if (w_row_high) begin
                        w_state_next = SINGLE_TICK ? SCAN : RELEASE;
                    end
                end
                RELEASE: begin
                    if (!w_row_high) begin
                        w_state_next = HELD;
                    end else if (w_cnt_done) begin
                        w_state_next = SCAN;
                    end
                end
                default: w_state_next = SCAN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM process 3: control outputs driving the datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_latch       = 1'b0;
        w_accept      = 1'b0;
        w_release     = 1'b0;
        w_rotate      = 1'b0;
        w_db_cnt_next = r_db_cnt;
        if (w_tick) begin
            unique case (r_state)
                SCAN: begin
                    if (w_hit.valid) begin
                        w_latch       = 1'b1;
                        w_db_cnt_next = DB_ONE;
                        w_accept      = SINGLE_TICK;
                    end else begin
                        w_rotate = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (w_row_match) begin
                        w_db_cnt_next = w_cnt_inc;
                        w_accept      = w_cnt_done;
                    end else begin
                        w_rotate = 1'b1;
                    end
                end
                HELD: begin
                    // Only the latched row is watched; other keys are ignored.
                    if (w_row_high) begin
                        w_db_cnt_next = DB_ONE;
                        w_release     = SINGLE_TICK;
                        w_rotate      = SINGLE_TICK;
                    end
                end
                RELEASE: begin
                    if (w_row_high) begin
                        w_db_cnt_next = w_cnt_inc;
                        w_release     = w_cnt_done;
                        w_rotate      = w_cnt_done;
                    end
                end
                default: begin
                    w_rotate = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_col       <= COL_RESET;
            r_col_idx   <= 2'd0;
            r_row_idx   <= 2'd0;
            r_cand      <= 4'h0;
            r_db_cnt    <= '0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_digits    <= 32'h0;
        end else begin
            r_key_valid <= w_accept;
            r_db_cnt    <= w_db_cnt_next;
            if (w_latch) begin
                r_row_idx <= w_hit.idx;
                r_cand    <= w_cand_new;
            end
            if (w_rotate) begin
                r_col     <= {r_col[2:0], r_col[3]};
                r_col_idx <= r_col_idx + 2'd1;
            end
            if (w_accept) begin
                r_key_code <= w_accept_code;
                r_digits   <= {r_digits[27:0], w_accept_code};
                r_key_held <= 1'b1;
            end else if (w_release) begin
                r_key_held <= 1'b0;
            end
        end
    end

    assign o_col       = r_col;
    assign o_key_code  = r_key_code;
    assign o_key_valid = r_key_valid;
    assign o_key_held  = r_key_held;
    assign o_digits    = r_digits;

endmodule

// File: tb/tb_keypad_scanner.sv
// ----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV = 4, DEBOUNCE_TICKS = 3.
// A small keypad model pulls one row low while its key's column is driven.
// ----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV       = 4;
    localparam int unsigned DEBOUNCE_TICKS = 3;

    logic        clk;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [31:0] digits;

    // Keypad model controls
    logic       press_en;
    logic [1:0] press_r;
    logic [1:0] press_c;
    logic       ghost_en;

    int n_checks;
    int n_errors;
    int n_valid;
    int base;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_row       (row),
        .o_col       (col),
        .o_key_code  (key_code),
        .o_key_valid (key_valid),
        .o_key_held  (key_held),
        .o_digits    (digits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: pressed key pulls its row low only while its column is driven.
    // Ghost mode shows rows 1100 whenever column 1 is driven.
    always_comb begin
        row = 4'b1111;
        if (press_en && (col[press_c] == 1'b0)) row[press_r] = 1'b0;
        if (ghost_en && (col == 4'b1101)) row = 4'b1100;
    end

    // Count key_valid pulses as seen at sample points.
    initial n_valid = 0;
    always @(negedge clk) if (key_valid) n_valid++;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " col"}, {28'h0, col}, 32'he);
        check({tag, " key_code"}, {28'h0, key_code}, 32'h0);
        check({tag, " key_valid"}, {31'h0, key_valid}, 32'h0);
        check({tag, " key_held"}, {31'h0, key_held}, 32'h0);
        check({tag, " digits"}, digits, 32'h0);
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        press_r  = r;
        press_c  = c;
        press_en = 1'b1;
    endtask

    // Returns at the first sample point where col newly becomes target,
    // which is the cycle right after a tick (divider count = 0).
    task automatic wait_col(input string tag, input logic [3:0] target);
        int n = 0;
        while (col == target && n < 64) begin @(negedge clk); n++; end
        while (col != target && n < 64) begin @(negedge clk); n++; end
        check(tag, {28'h0, col}, {28'h0, target});
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!key_valid && n < 100) begin @(negedge clk); n++; end
        check(tag, {31'h0, key_valid}, 32'h1);
    endtask

    task automatic wait_held_low(input string tag);
        int n = 0;
        while (key_held && n < 100) begin @(negedge clk); n++; end
        check(tag, {31'h0, key_held}, 32'h0);
    endtask

    task automatic key_cycle(input string tag, input logic [1:0] r, input logic [1:0] c,
                             input logic [3:0] code);
        press(r, c);
        wait_valid({tag, " valid"});
        check({tag, " code"}, {28'h0, key_code}, {28'h0, code});
        press_en = 1'b0;
        wait_held_low({tag, " released"});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        press_en = 1'b0;
        press_r  = 2'd0;
        press_c  = 2'd0;
        ghost_en = 1'b0;
        reset    = 1'b0;

        // Reset and idle column sweep
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("sweep hold", {28'h0, col}, 32'he);
        @(negedge clk);
        check("sweep col1", {28'h0, col}, 32'hd);
        repeat (4) @(negedge clk);
        check("sweep col2", {28'h0, col}, 32'hb);
        repeat (4) @(negedge clk);
        check("sweep col3", {28'h0, col}, 32'h7);
        repeat (4) @(negedge clk);
        check("sweep wrap", {28'h0, col}, 32'he);
        check("sweep no valid", n_valid, 0);
        check("sweep digits", digits, 32'h0);

        // Key 9 (row2, col2): valid exactly after the third matching tick
        press(2'd2, 2'd2);
        wait_col("k9 reach col2", 4'b1011);
        repeat (11) @(negedge clk);
        check("k9 early valid", {31'h0, key_valid}, 32'h0);
        @(negedge clk);
        check("k9 valid", {31'h0, key_valid}, 32'h1);
        check("k9 code", {28'h0, key_code}, 32'h9);
        check("k9 digits", digits, 32'h9);
        check("k9 held", {31'h0, key_held}, 32'h1);
        press_en = 1'b0;
        @(negedge clk);
        check("k9 pulse width", {31'h0, key_valid}, 32'h0);
        repeat (10) @(negedge clk);
        check("k9 held until release", {31'h0, key_held}, 32'h1);
        @(negedge clk);
        check("k9 release", {31'h0, key_held}, 32'h0);
        check("k9 resume col", {28'h0, col}, 32'h7);
        check("k9 one pulse", n_valid, 1);

        // Sequence 1, A, 0, D from a fresh reset
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        base = n_valid;
        key_cycle("k1", 2'd0, 2'd0, 4'h1);
        key_cycle("kA", 2'd0, 2'd3, 4'hA);
        key_cycle("k0", 2'd3, 2'd0, 4'h0);
        key_cycle("kD", 2'd3, 2'd3, 4'hD);
        check("seq digits", digits, 32'h00001a0d);
        check("seq pulses", n_valid - base, 4);

        // Key 5 bounces shorter than the debounce window
        wait_col("b5 reach col1 a", 4'b1101);
        press(2'd1, 2'd1);
        repeat (4) @(negedge clk);
        press_en = 1'b0;
        wait_col("b5 reach col1 b", 4'b1101);
        press(2'd1, 2'd1);
        repeat (8) @(negedge clk);
        press_en = 1'b0;
        repeat (8) @(negedge clk);
        check("b5 no valid", n_valid - base, 4);
        check("b5 digits", digits, 32'h00001a0d);
        check("b5 not held", {31'h0, key_held}, 32'h0);

        // Key 2 with a one-tick bounce on release
        press(2'd0, 2'd1);
        wait_valid("r2 valid");
        press_en = 1'b0;
        repeat (4) @(negedge clk);
        press(2'd0, 2'd1);
        repeat (8) @(negedge clk);
        check("r2 still held", {31'h0, key_held}, 32'h1);
        press_en = 1'b0;
        wait_held_low("r2 released");
        check("r2 single pulse", n_valid - base, 5);
        check("r2 digits", digits, 32'h0001a0d2);

        // Two rows low on column 1 is not a press
        ghost_en = 1'b1;
        wait_col("ghost reach col1", 4'b1101);
        repeat (4) @(negedge clk);
        check("ghost rotates", {28'h0, col}, 32'hb);
        repeat (16) @(negedge clk);
        ghost_en = 1'b0;
        check("ghost no valid", n_valid - base, 5);
        check("ghost digits", digits, 32'h0001a0d2);

        // Reset during debounce of key 7 (row2, col0)
        wait_col("rst7 reach col1", 4'b1101);
        press(2'd2, 2'd0);
        wait_col("rst7 reach col0", 4'b1110);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst7");
        press_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        base = n_valid;
        repeat (24) @(negedge clk);
        check("rst7 no valid", n_valid - base, 0);

        // Reset while key E (row3, col2) is held
        press(2'd3, 2'd2);
        wait_valid("rstE valid");
        check("rstE digits", digits, 32'he);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rstE");
        press_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        base = n_valid;
        repeat (24) @(negedge clk);
        check("rstE no valid", n_valid - base, 0);
        check("rstE digits after", digits, 32'h0);
        check("rstE not held", {31'h0, key_held}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
